// File: rtl/sev_seg_pkg.sv
// rtl/sev_seg_pkg.sv - shared types and constants for the seven-segment scan controller
package sev_seg_pkg;

   localparam logic [7:0] SEG_BLANK_N = 8'hFF;

   typedef logic [3:0] phase_t;

   typedef enum logic {
      IDLE,
      SCAN
   } scan_state_t;

endpackage

// File: rtl/sev_seg_dec.sv
// rtl/sev_seg_dec.sv - combinational BCD to active-high {dp,g,f,e,d,c,b,a} decoder
module sev_seg_dec
   import sev_seg_pkg::*;
(
   input  logic [3:0] bcd_i,
   input  logic       special_i,
   output logic [7:0] seg_o
);

   always_comb begin
      seg_o = 8'h00;
      if (special_i) begin
         seg_o = 8'h40;
      end else begin
         case (bcd_i)
            4'h0:    seg_o = 8'h3F;
            4'h1:    seg_o = 8'h06;
            4'h2:    seg_o = 8'h5B;
            4'h3:    seg_o = 8'h4F;
            4'h4:    seg_o = 8'h66;
            4'h5:    seg_o = 8'h6D;
            4'h6:    seg_o = 8'h7D;
            4'h7:    seg_o = 8'h07;
            4'h8:    seg_o = 8'h7F;
            4'h9:    seg_o = 8'h6F;
            default: seg_o = 8'h00;
         endcase
      end
   end

endmodule

// File: rtl/sev_seg_scan_ctrl.sv
// rtl/sev_seg_scan_ctrl.sv - time-multiplexed common-anode display scanner with PWM brightness
module sev_seg_scan_ctrl
   import sev_seg_pkg::*;
#(
   parameter int N_DIGITS  = 8,
   parameter int PHASE_LEN = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic [4*N_DIGITS-1:0] digits,
   input  logic [N_DIGITS-1:0]   special_mask,
   input  logic [N_DIGITS-1:0]   dp_mask,
   input  logic [3:0]            brightness,
   output logic [N_DIGITS-1:0]   an_n,
   output logic [7:0]            seg_n,
   output logic                  frame_tick
);

   localparam int CW = (PHASE_LEN > 1) ? $clog2(PHASE_LEN) : 1;
   localparam int DW = $clog2(N_DIGITS);

   scan_state_t           state_q, state_d;
   logic [CW-1:0]         cyc_q, cyc_d;
   phase_t                phase_q, phase_d;
   logic [DW-1:0]         digit_q, digit_d;
   logic [4*N_DIGITS-1:0] dig_sh_q, dig_sh_d;
   logic [N_DIGITS-1:0]   spc_sh_q, spc_sh_d;
   logic [N_DIGITS-1:0]   dp_sh_q, dp_sh_d;
   logic [N_DIGITS-1:0]   an_n_q, an_n_d;
   logic [7:0]            seg_n_q, seg_n_d;
   logic                  tick_q, tick_d;
   logic                  snap;
   logic [7:0]            dec_seg;
   logic [7:0]            lit_seg;

   sev_seg_dec u_dec (
      .bcd_i     (dig_sh_q[4*digit_q +: 4]),
      .special_i (spc_sh_q[digit_q]),
      .seg_o     (dec_seg)
   );

   // A dash digit never shows its decimal point.
   assign lit_seg = spc_sh_q[digit_q] ? dec_seg : (dec_seg | {dp_sh_q[digit_q], 7'b0});

   always_comb begin
      state_d  = state_q;
      cyc_d    = cyc_q;
      phase_d  = phase_q;
      digit_d  = digit_q;
      an_n_d   = '1;
      seg_n_d  = SEG_BLANK_N;
      snap     = 1'b0;
      case (state_q)
         IDLE: begin
            cyc_d   = '0;
            phase_d = '0;
            digit_d = '0;
            if (enable) begin
               state_d = SCAN;
               snap    = 1'b1;
            end
         end
         SCAN: begin
            if (!enable) begin
               state_d = IDLE;
               cyc_d   = '0;
               phase_d = '0;
               digit_d = '0;
            end else begin
               if (cyc_q == CW'(PHASE_LEN - 1)) begin
                  cyc_d   = '0;
                  phase_d = phase_q + 4'd1;
                  if (phase_q == 4'hF) begin
                     if (digit_q == DW'(N_DIGITS - 1)) begin
                        digit_d = '0;
                        snap    = 1'b1;
                     end else begin
                        digit_d = digit_q + 1'b1;
                     end
                  end
               end else begin
                  cyc_d = cyc_q + 1'b1;
               end
               if (phase_q <= brightness) begin
                  an_n_d  = ~(N_DIGITS'(1) << digit_q);
                  seg_n_d = ~lit_seg;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      dig_sh_d = snap ? digits       : dig_sh_q;
      spc_sh_d = snap ? special_mask : spc_sh_q;
      dp_sh_d  = snap ? dp_mask      : dp_sh_q;
      tick_d   = snap;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cyc_q    <= '0;
         phase_q  <= '0;
         digit_q  <= '0;
         dig_sh_q <= '0;
         spc_sh_q <= '0;
         dp_sh_q  <= '0;
         an_n_q   <= '1;
         seg_n_q  <= SEG_BLANK_N;
         tick_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cyc_q    <= cyc_d;
         phase_q  <= phase_d;
         digit_q  <= digit_d;
         dig_sh_q <= dig_sh_d;
         spc_sh_q <= spc_sh_d;
         dp_sh_q  <= dp_sh_d;
         an_n_q   <= an_n_d;
         seg_n_q  <= seg_n_d;
         tick_q   <= tick_d;
      end
   end

   assign an_n       = an_n_q;
   assign seg_n      = seg_n_q;
   assign frame_tick = tick_q;

endmodule

// File: tb/tb_sev_seg_scan_ctrl.sv
// tb/tb_sev_seg_scan_ctrl.sv - directed table-driven bench for sev_seg_scan_ctrl
module tb_sev_seg_scan_ctrl;

   localparam int N     = 8;
   localparam int PL    = 4;
   localparam int SLOT  = 16 * PL;
   localparam int FRAME = N * SLOT;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic [31:0] digits;
   logic [7:0]  special_mask;
   logic [7:0]  dp_mask;
   logic [3:0]  brightness;
   logic [7:0]  an_n;
   logic [7:0]  seg_n;
   logic        frame_tick;

   int pass_cnt  = 0;
   int total_cnt = 0;

   typedef struct packed {
      logic [31:0] digits;
      logic [7:0]  spc;
      logic [7:0]  dp;
      logic [3:0]  bright;
      logic [7:0]  lit;
      logic [63:0] seg;
   } vec_t;

   vec_t vecs [4];
   int   lit_cnt [8];
   int   bad_cnt [8];
   int   tick_bad;
   int   d;
   int   ph;
   int   waited;
   logic [7:0] exp_an;
   logic [7:0] exp_seg;

   sev_seg_scan_ctrl #(.N_DIGITS(N), .PHASE_LEN(PL)) dut (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable),
      .digits       (digits),
      .special_mask (special_mask),
      .dp_mask      (dp_mask),
      .brightness   (brightness),
      .an_n         (an_n),
      .seg_n        (seg_n),
      .frame_tick   (frame_tick)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   initial begin
      vecs[0] = '{32'h76543210, 8'h00, 8'h00, 4'd15, 8'd64, 64'hF8_82_92_99_B0_A4_F9_C0};
      vecs[1] = '{32'h76543210, 8'h00, 8'h00, 4'd3,  8'd16, 64'hF8_82_92_99_B0_A4_F9_C0};
      vecs[2] = '{32'h76543210, 8'h00, 8'h00, 4'd0,  8'd4,  64'hF8_82_92_99_B0_A4_F9_C0};
      vecs[3] = '{32'hFA980510, 8'h04, 8'h86, 4'd7,  8'd32, 64'h7F_FF_90_80_C0_BF_79_C0};

      rst          = 1'b1;
      enable       = 1'b1;
      digits       = 32'h76543210;
      special_mask = 8'h00;
      dp_mask      = 8'h00;
      brightness   = 4'd15;

      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst_an", an_n, 8'hFF);
         chk("rst_seg", seg_n, 8'hFF);
         chk("rst_tick", frame_tick, 1'b0);
      end
      rst = 1'b0;
      step();
      chk("first_tick", frame_tick, 1'b1);
      chk("entry_blank", an_n, 8'hFF);
      step();
      chk("first_an", an_n, 8'hFE);
      chk("first_seg", seg_n, 8'hC0);

      for (int v = 0; v < 4; v++) begin
         digits       = vecs[v].digits;
         special_mask = vecs[v].spc;
         dp_mask      = vecs[v].dp;
         brightness   = vecs[v].bright;
         enable       = 1'b0;
         step();
         enable = 1'b1;
         step();
         chk($sformatf("v%0d_entry_tick", v), frame_tick, 1'b1);
         for (int j = 0; j < 8; j++) begin
            lit_cnt[j] = 0;
            bad_cnt[j] = 0;
         end
         tick_bad = 0;
         for (int k = 1; k <= FRAME; k++) begin
            step();
            d  = (k - 1) / SLOT;
            ph = ((k - 1) % SLOT) / PL;
            if (ph <= int'(vecs[v].bright)) begin
               exp_an  = ~(8'b1 << d);
               exp_seg = vecs[v].seg[8*d +: 8];
            end else begin
               exp_an  = 8'hFF;
               exp_seg = 8'hFF;
            end
            if (an_n !== exp_an || seg_n !== exp_seg) bad_cnt[d]++;
            if (an_n != 8'hFF) lit_cnt[d]++;
            if (k < FRAME && frame_tick) tick_bad++;
         end
         chk($sformatf("v%0d_frame_tick", v), frame_tick, 1'b1);
         chk($sformatf("v%0d_stray_ticks", v), tick_bad, 0);
         for (int j = 0; j < 8; j++) begin
            chk($sformatf("v%0d_d%0d_lit_cycles", v, j), lit_cnt[j], vecs[v].lit);
            chk($sformatf("v%0d_d%0d_drive_errs", v, j), bad_cnt[j], 0);
         end
      end

      digits       = 32'h76543210;
      special_mask = 8'h00;
      dp_mask      = 8'h00;
      brightness   = 4'd15;
      enable       = 1'b0;
      step();
      enable = 1'b1;
      step();
      repeat (100) step();
      digits = 32'h11111111;
      repeat (40) step();
      chk("snap_old_an", an_n, 8'hFB);
      chk("snap_old_seg", seg_n, 8'hA4);
      waited = 0;
      while (!frame_tick && waited < 600) begin
         step();
         waited++;
      end
      chk("snap_tick_seen", frame_tick, 1'b1);
      repeat (140) step();
      chk("snap_new_an", an_n, 8'hFB);
      chk("snap_new_seg", seg_n, 8'hF9);

      enable = 1'b0;
      step();
      enable = 1'b1;
      step();
      repeat (10) step();
      chk("en_lit_an", an_n, 8'hFE);
      enable = 1'b0;
      step();
      chk("en_drop_an", an_n, 8'hFF);
      chk("en_drop_seg", seg_n, 8'hFF);
      step();
      chk("en_idle_an", an_n, 8'hFF);
      enable = 1'b1;
      step();
      chk("en_re_tick", frame_tick, 1'b1);
      step();
      chk("en_re_an", an_n, 8'hFE);
      chk("en_re_seg", seg_n, 8'hF9);

      repeat (5) step();
      rst = 1'b1;
      step();
      chk("mid_rst_an", an_n, 8'hFF);
      chk("mid_rst_seg", seg_n, 8'hFF);
      chk("mid_rst_tick", frame_tick, 1'b0);
      rst = 1'b0;
      step();
      chk("post_rst_tick", frame_tick, 1'b1);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
